// File: rtl/c5315_pkg.sv
// Shared constants, pi/po field map and lane result type for the c5315 benchmark core.
// Every pi/po offset lives here so the top-level wiring never uses bare numbers.
package c5315_pkg;

    localparam int W      = 9;
    localparam int PD_W   = 93;
    localparam int PI_W   = 178;
    localparam int PO_W   = 123;
    localparam int RSVD_W = 40;
    localparam int LANE_W = 13;
    localparam int N_LANE = 2;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_NOTA  = 3'b101;
    localparam logic [2:0] OP_PASSA = 3'b110;
    localparam logic [2:0] OP_PASSB = 3'b111;

    // pi field offsets
    localparam int A0_LSB   = 0;
    localparam int B0_LSB   = 9;
    localparam int A1_LSB   = 18;
    localparam int B1_LSB   = 27;
    localparam int OP0_LSB  = 36;
    localparam int OP1_LSB  = 39;
    localparam int CIN0_BIT = 42;
    localparam int CIN1_BIT = 43;
    localparam int RSVD_LSB = 44;
    localparam int PD_LSB   = 84;
    localparam int INV_BIT  = 177;

    // po field offsets; lane n occupies [n*LANE_W +: LANE_W]
    localparam int EQ0_BIT  = 26;
    localparam int LT0_BIT  = 27;
    localparam int EQ1_BIT  = 28;
    localparam int LT1_BIT  = 29;
    localparam int PDO_LSB  = 30;

    typedef struct packed {
        logic [W-1:0] r;
        logic         cout;
        logic         zero;
        logic         par;
        logic         ovf;
    } lane_res_t;

    // Lane word as it appears in po: r at the base, then cout, zero, par, ovf.
    function automatic logic [LANE_W-1:0] pack_lane(input lane_res_t res);
        return {res.ovf, res.par, res.zero, res.cout, res.r};
    endfunction

endpackage

// File: rtl/c5315_alu_lane.sv
// One purely combinational 9-bit ALU lane: eight ops, status flags, and op-independent compares.
module c5315_alu_lane
    import c5315_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    input  logic         cin,
    output lane_res_t    res,
    output logic         eq,
    output logic         lt
);

    logic [W-1:0] b_add;
    logic [W:0]   sum;
    logic         is_arith;

    // SUB reuses the adder with the second operand inverted; cin supplies the +1.
    assign b_add    = (op == OP_SUB) ? ~b : b;
    assign sum      = {1'b0, a} + {1'b0, b_add} + {{W{1'b0}}, cin};
    assign is_arith = (op == OP_ADD) || (op == OP_SUB);

    always_comb begin
        res = '0;
        case (op)
            OP_ADD,
            OP_SUB:   res.r = sum[W-1:0];
            OP_AND:   res.r = a & b;
            OP_OR:    res.r = a | b;
            OP_XOR:   res.r = a ^ b;
            OP_NOTA:  res.r = ~a;
            OP_PASSA: res.r = a;
            default:  res.r = b;
        endcase
        res.cout = is_arith & sum[W];
        // Signed overflow: both addend signs agree and the result sign does not.
        res.ovf  = is_arith & (a[W-1] == b_add[W-1]) & (sum[W-1] != a[W-1]);
        res.zero = (res.r == '0);
        res.par  = ^res.r;
    end

    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/c5315_core.sv
// Registered two-lane ALU with a 93-bit pass/invert side channel; every po bit has one cycle of latency.
module c5315_core
    import c5315_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PI_W-1:0] pi,
    output logic [PO_W-1:0] po
);

    logic [W-1:0]      a_s   [N_LANE];
    logic [W-1:0]      b_s   [N_LANE];
    logic [2:0]        op_s  [N_LANE];
    logic [N_LANE-1:0] cin_s;
    lane_res_t         res_s [N_LANE];
    logic [N_LANE-1:0] eq_s;
    logic [N_LANE-1:0] lt_s;

    logic [PD_W-1:0]   pd;
    logic              inv;
    logic [RSVD_W-1:0] rsvd_unused;

    logic [PO_W-1:0]   po_d;
    logic [PO_W-1:0]   po_q;

    assign a_s[0]   = pi[A0_LSB +: W];
    assign b_s[0]   = pi[B0_LSB +: W];
    assign a_s[1]   = pi[A1_LSB +: W];
    assign b_s[1]   = pi[B1_LSB +: W];
    assign op_s[0]  = pi[OP0_LSB +: 3];
    assign op_s[1]  = pi[OP1_LSB +: 3];
    assign cin_s[0] = pi[CIN0_BIT];
    assign cin_s[1] = pi[CIN1_BIT];
    assign pd       = pi[PD_LSB +: PD_W];
    assign inv      = pi[INV_BIT];

    // Reserved bits are deliberately left out of every output function.
    assign rsvd_unused = pi[RSVD_LSB +: RSVD_W];

    generate
        for (genvar gi = 0; gi < N_LANE; gi++) begin : g_lane
            c5315_alu_lane u_lane (
                .a   (a_s[gi]),
                .b   (b_s[gi]),
                .op  (op_s[gi]),
                .cin (cin_s[gi]),
                .res (res_s[gi]),
                .eq  (eq_s[gi]),
                .lt  (lt_s[gi])
            );
        end
    endgenerate

    always_comb begin
        po_d = '0;
        for (int i = 0; i < N_LANE; i++) begin
            po_d[i*LANE_W +: LANE_W] = pack_lane(res_s[i]);
        end
        po_d[EQ0_BIT]            = eq_s[0];
        po_d[LT0_BIT]            = lt_s[0];
        po_d[EQ1_BIT]            = eq_s[1];
        po_d[LT1_BIT]            = lt_s[1];
        po_d[PDO_LSB +: PD_W]    = pd ^ {PD_W{inv}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            po_q <= '0;
        end else begin
            po_q <= po_d;
        end
    end

    assign po = po_q;

endmodule

// File: tb/tb_c5315_core.sv
// Directed-vector bench for c5315_core; expected po words are assembled from hand-computed fields.
module tb_c5315_core;

    logic         clk;
    logic         rst_n;
    logic [177:0] pi;
    logic [122:0] po;

    int n_cmp = 0;
    int n_bad = 0;
    logic [122:0] prev_exp;

    c5315_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pi    (pi),
        .po    (po)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [122:0] obs, input logic [122:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] mk_lane(input logic [8:0] r, input logic cout, input logic zero,
                                            input logic par, input logic ovf);
        return {ovf, par, zero, cout, r};
    endfunction

    // flags = {lt1, eq1, lt0, eq0}
    function automatic logic [122:0] mk_po(input logic [12:0] l0, input logic [12:0] l1,
                                           input logic [3:0] flags, input logic [92:0] pdo);
        return {pdo, flags, l1, l0};
    endfunction

    function automatic logic [177:0] mk_pi(input logic [8:0] a0, input logic [8:0] b0,
                                           input logic [8:0] a1, input logic [8:0] b1,
                                           input logic [2:0] op0, input logic [2:0] op1,
                                           input logic cin0, input logic cin1,
                                           input logic [39:0] rsvd, input logic [92:0] pdv,
                                           input logic inv);
        return {inv, pdv, rsvd, cin1, cin0, op1, op0, b1, a1, b0, a0};
    endfunction

    // Drive at negedge, confirm po has not moved yet, then check after the next rising edge.
    task automatic apply(input string tag, input logic [177:0] v, input logic [122:0] exp);
        @(negedge clk);
        pi = v;
        #1;
        check_eq({tag, "_hold"}, po, prev_exp);
        @(posedge clk);
        #1;
        check_eq(tag, po, exp);
        prev_exp = exp;
        $display("vec %-10s pi=%h po=%h", tag, v, po);
    endtask

    logic [8:0] sw_r [6] = '{9'h030, 9'h0FC, 9'h0CC, 9'h10F, 9'h0F0, 9'h03C};
    logic       sw_p [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        logic [92:0]  pd_alt;
        logic [39:0]  r40;
        logic [63:0]  t64;
        logic [122:0] exp_zero;
        logic [122:0] e;
        logic [177:0] v;
        logic [12:0]  l;

        for (int i = 0; i < 93; i++) pd_alt[i] = (i % 2 == 0);
        exp_zero = mk_po(mk_lane(9'h000, 0, 1, 0, 0), mk_lane(9'h000, 0, 1, 0, 0), 4'b0101, '0);

        // Reset: async assert with no edge, hold across edges, first capture uses current pi.
        pi    = '1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rst_async", po, '0);
        $display("vec rst_async po=%h", po);
        pi = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_hold", po, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_release", po, '0);
        @(posedge clk);
        #1;
        check_eq("first_cap", po, exp_zero);
        prev_exp = exp_zero;
        $display("vec first_cap po=%h", po);

        // ADD lane 0 wraps to zero with carry; lane 1 compares equal.
        v = mk_pi(9'h1FF, 9'h001, 9'h000, 9'h000, 3'b000, 3'b000, 0, 0, '0, '0, 0);
        e = mk_po(mk_lane(9'h000, 1, 1, 0, 0), mk_lane(9'h000, 0, 1, 0, 0), 4'b0100, '0);
        apply("add_l0", v, e);
        check_eq("add_l0_lane", {110'd0, po[12:0]}, {110'd0, mk_lane(9'h000, 1, 1, 0, 0)});

        // ADD lane 1 signed overflow.
        v = mk_pi(9'h000, 9'h000, 9'h0FF, 9'h001, 3'b000, 3'b000, 0, 0, '0, '0, 0);
        e = mk_po(mk_lane(9'h000, 0, 1, 0, 0), mk_lane(9'h100, 0, 0, 1, 1), 4'b0001, '0);
        apply("ovf_l1", v, e);
        check_eq("ovf_l1_lane", {110'd0, po[25:13]}, {110'd0, mk_lane(9'h100, 0, 0, 1, 1)});

        // SUB lane 0 with borrow; lane 1 SUB 0-0 gives zero with no borrow.
        v = mk_pi(9'h005, 9'h007, 9'h000, 9'h000, 3'b001, 3'b001, 1, 1, '0, '0, 0);
        e = mk_po(mk_lane(9'h1FE, 0, 0, 0, 0), mk_lane(9'h000, 1, 1, 0, 0), 4'b0110, '0);
        apply("sub_l0", v, e);
        check_eq("sub_lt0", {122'd0, po[27]}, {122'd0, 1'b1});

        // Logic/pass sweep on both lanes, alternating side-channel inversion.
        for (int k = 0; k < 6; k++) begin
            logic [2:0] opk;
            logic       invk;
            opk  = 3'(k + 2);
            invk = k[0];
            l = mk_lane(sw_r[k], 0, 0, sw_p[k], 0);
            v = mk_pi(9'h0F0, 9'h03C, 9'h0F0, 9'h03C, opk, opk, 1, 1, '0, pd_alt, invk);
            e = mk_po(l, l, 4'b0000, invk ? ~pd_alt : pd_alt);
            apply($sformatf("logic_op%0d", opk), v, e);
        end

        // Side channel straight and inverted.
        v = mk_pi(9'h000, 9'h000, 9'h000, 9'h000, 3'b000, 3'b000, 0, 0, '0, pd_alt, 0);
        apply("pd_pass", v, mk_po(mk_lane(0, 0, 1, 0, 0), mk_lane(0, 0, 1, 0, 0), 4'b0101, pd_alt));
        check_eq("pd_pass_field", {30'd0, po[122:30]}, {30'd0, pd_alt});
        v = mk_pi(9'h000, 9'h000, 9'h000, 9'h000, 3'b000, 3'b000, 0, 0, '0, pd_alt, 1);
        apply("pd_inv", v, mk_po(mk_lane(0, 0, 1, 0, 0), mk_lane(0, 0, 1, 0, 0), 4'b0101, ~pd_alt));
        check_eq("pd_inv_field", {30'd0, po[122:30]}, {30'd0, ~pd_alt});

        // Reserved bits toggled randomly must not change the result.
        e = mk_po(mk_lane(9'h1FE, 0, 0, 0, 0), mk_lane(9'h000, 1, 1, 0, 0), 4'b0110, pd_alt);
        for (int k = 0; k < 3; k++) begin
            t64 = {$urandom(), $urandom()};
            r40 = t64[39:0];
            v = mk_pi(9'h005, 9'h007, 9'h000, 9'h000, 3'b001, 3'b001, 1, 1, r40, pd_alt, 0);
            apply($sformatf("rsvd_%0d", k), v, e);
        end

        // Equal operands with a non-trivial ADD result.
        v = mk_pi(9'h055, 9'h055, 9'h055, 9'h055, 3'b000, 3'b000, 0, 1, '0, '0, 0);
        e = mk_po(mk_lane(9'h0AA, 0, 0, 0, 0), mk_lane(9'h0AB, 0, 0, 1, 0), 4'b0101, '0);
        apply("eq_add", v, e);

        // Reset asserted mid-stream clears po at once.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid", po, '0);
        $display("vec rst_mid po=%h", po);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/c5315_core.md
# c5315_core

Registered two-lane 9-bit ALU with a wide pass/invert datapath, sized to the c5315 benchmark's 178-input / 123-output footprint. Each lane computes one of eight arithmetic or logic operations plus status flags. A 93-bit side channel is passed through, optionally inverted. All outputs are registered, with one clock of latency. The block sits as a clocked benchmark core in the fault-dictionary test flow, where a golden instance and a fault-injected instance are compared output-for-output.

## Interface
- No parameters. Widths are fixed constants in the package.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock domain, asynchronous assert, active-low.
- pi  in  178  primary input vector, field map below.
- po  out  123  primary output vector, registered, field map below.

Input fields:
- a0 = pi[8:0]; b0 = pi[17:9]; a1 = pi[26:18]; b1 = pi[35:27].
- op0 = pi[38:36]; op1 = pi[41:39]; cin0 = pi[42]; cin1 = pi[43].
- pi[83:44] reserved; ignored.
- pd = pi[176:84] (93 bits); inv = pi[177].

Output fields (lane n base: n=0 → bit 0, n=1 → bit 13):
- r = [base+8:base]; cout = [base+9]; zero = [base+10]; par = [base+11]; ovf = [base+12].
- eq0 = po[26]; lt0 = po[27]; eq1 = po[28]; lt1 = po[29].
- po[122:30] = pd ^ {93{inv}}.

## Operation
- Opcodes (per lane, 3 bits):
  - 000 ADD: {cout,r} = a + b + cin.
  - 001 SUB: {cout,r} = a + ~b + cin. cin=1 gives a−b; cout=1 means no borrow.
  - 010 AND; 011 OR; 100 XOR.
  - 101 NOTA: r = ~a.
  - 110 PASSA: r = a.
  - 111 PASSB: r = b.
- Logic and pass ops force cout=0 and ovf=0.
- Arithmetic is 10-bit unsigned; r is the low 9 bits.
- ovf (ADD/SUB only): signed two's-complement overflow, i.e. the sign bits of both operands actually added (a and b, or a and ~b) are equal and r[8] differs from them.
- zero = (r == 0).
- par = ^r, so 1 when r has an odd number of ones.
- eq = (a == b); lt = (a < b) unsigned. Both are independent of op.
- Reserved inputs have no effect on any output.
- No internal state other than the output register.
- X on ignored fields must not propagate.

## Timing
- All po bits are captured on the rising edge of clk from purely combinational functions of pi.
- Latency is exactly one cycle: pi sampled at edge k appears on po after edge k.
- po holds its value between edges. There is no enable and no handshake.
- Reset drives all 123 po bits to 0 immediately, independent of clk.
- Release is synchronized by the caller. The first capture after release uses the current pi.
- Reset asserted mid-stream clears po at once; no partial update may occur.
- A new pi on every cycle is legal. There is no back-pressure.

## Structure
- Package c5315_pkg holds:
  - the opcode localparams (OP_ADD … OP_PASSB);
  - the field offsets and widths listed above (W=9, PD_W=93, PI_W=178, PO_W=123);
  - a lane-result struct {r, cout, zero, par, ovf}.
- Sub-module c5315_alu_lane, purely combinational and instantiated twice: inputs a, b, op, cin; outputs the lane struct plus eq and lt.
- The top level does the pi unpacking, the pd inversion, po packing, and the single 123-bit async-reset register.

## Test plan
- Reset: set pi to all ones, then assert rst_n=0 with no clock edge → po == 0 immediately. Hold reset across edges → po stays 0.
- ADD, lane 0, a0=0x1FF, b0=0x001, cin0=0, op0=000 → next edge: r=0x000, cout=1, zero=1, par=0, ovf=0, eq0=0, lt0=0.
- Overflow, lane 1, ADD a1=0x0FF, b1=0x001, cin1=0 → r=0x100, cout=0, ovf=1, par=1, zero=0.
- SUB, lane 0, a0=5, b0=7, cin0=1, op0=001 → r=0x1FE, cout=0, ovf=0, lt0=1.
- Logic sweep on a=0x0F0, b=0x03C, all lanes:
  - AND → 0x030; OR → 0x0FC; XOR → 0x0CC.
  - NOTA → 0x10F; PASSA → 0x0F0; PASSB → 0x03C.
  - cout=ovf=0 throughout.
- Side channel:
  - pd=alternating 1010…, inv=0 → po[122:30] equals pd.
  - inv=1 → bitwise complement of pd.
  - Toggle reserved pi[83:44] randomly → po unchanged.
  - Back-to-back vectors on consecutive cycles each appear after exactly one edge.
